// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MEM-stage data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmemState_t;

    localparam logic [31:0] c_ERR_READ_DATA = 32'h0000_0000;

    // Word-address width for an array of the given depth; never below 1 bit.
    function automatic int wordAddrWidth(input int depthWords);
        return (depthWords > 1) ? $clog2(depthWords) : 1;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem_array
// Description : Single-port word RAM, synchronous write and registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  i_writeEnable,
    input  logic                  i_readEnable,
    input  logic [ADDR_WIDTH-1:0] i_wordAddr,
    input  logic [31:0]           i_writeData,
    output logic [31:0]           o_readData
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_readData;

    // Contents are deliberately not reset; the read register holds between reads.
    always_ff @(posedge clk) begin
        if (i_writeEnable) begin
            r_mem[i_wordAddr] <= i_writeData;
        end
        if (i_readEnable) begin
            r_readData <= r_mem[i_wordAddr];
        end
    end

    assign o_readData = r_readData;

endmodule : mips_dmem_array
`default_nettype wire

// File: rtl/mips_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem_responder
// Description : MEM-stage load/store responder with fixed wait states and stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_responder
    import mips_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        GlobalClock,
    input  logic        GlobalReset,
    input  logic [31:0] MemAddr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemWriteData,
    output logic [31:0] MemReadData,
    output logic        MemStall,
    output logic        AccessError
);

    localparam int         c_AW         = wordAddrWidth(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT_LOAD  = 4'(WAIT_CYCLES);
    localparam logic [29:0] c_DEPTH     = 30'(DEPTH_WORDS);

    dmemState_t  r_state;
    logic [3:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_writeData;
    logic        r_read;
    logic        r_write;
    logic        r_readZero;
    logic        r_accessError;

    logic        w_request;
    logic        w_inIdle;
    logic        w_doAccess;
    logic [31:0] w_accAddr;
    logic [31:0] w_accWriteData;
    logic        w_accRead;
    logic        w_accWrite;
    logic [31:0] w_offset;
    logic        w_err;
    logic [31:0] w_arrayReadData;

    assign w_request = MemRead | MemWrite;
    assign w_inIdle  = (r_state == IDLE);

    // With zero wait states the access happens on the sampling edge, so it
    // must use the live inputs instead of the not-yet-latched copies.
    assign w_accAddr      = w_inIdle ? MemAddr      : r_addr;
    assign w_accWriteData = w_inIdle ? MemWriteData : r_writeData;
    assign w_accRead      = w_inIdle ? MemRead      : r_read;
    assign w_accWrite     = w_inIdle ? MemWrite     : r_write;

    assign w_doAccess = !GlobalReset &&
                        ((w_inIdle && w_request && (WAIT_CYCLES == 0)) ||
                         ((r_state == WAIT) && (r_count == 4'd1)));

    assign w_offset = w_accAddr - BASE_ADDR;
    assign w_err    = (|w_offset[1:0]) ||
                      (w_accAddr < BASE_ADDR) ||
                      (w_offset[31:2] >= c_DEPTH) ||
                      (w_accRead && w_accWrite);

    mips_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_WIDTH  (c_AW)
    ) u_array (
        .clk           (GlobalClock),
        .i_writeEnable (w_doAccess && w_accWrite && !w_err),
        .i_readEnable  (w_doAccess && w_accRead && !w_err),
        .i_wordAddr    (w_offset[c_AW+1:2]),
        .i_writeData   (w_accWriteData),
        .o_readData    (w_arrayReadData)
    );

    always_ff @(posedge GlobalClock) begin
        if (GlobalReset) begin
            r_state       <= IDLE;
            r_count       <= 4'd0;
            r_addr        <= 32'd0;
            r_writeData   <= 32'd0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_readZero    <= 1'b1;
            r_accessError <= 1'b0;
        end else begin
            r_accessError <= 1'b0;
            if (w_doAccess) begin
                r_accessError <= w_err;
                if (w_err) begin
                    r_readZero <= 1'b1;
                end else if (w_accRead) begin
                    r_readZero <= 1'b0;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_request) begin
                        r_addr      <= MemAddr;
                        r_writeData <= MemWriteData;
                        r_read      <= MemRead;
                        r_write     <= MemWrite;
                        r_count     <= c_WAIT_LOAD;
                        r_state     <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MemStall    = (w_inIdle && w_request) || (r_state == WAIT);
    assign MemReadData = r_readZero ? c_ERR_READ_DATA : w_arrayReadData;
    assign AccessError = r_accessError;

endmodule : mips_dmem_responder
`default_nettype wire

// File: tb/tb_mips_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_dmem_responder
// Description : Directed self-checking bench for mips_dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_dmem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr, wdata, zAddr, zWdata;
    logic        rd, wr, zRd, zWr;
    logic [31:0] rdata, zRdata;
    logic        stall, err, zStall, zErr;

    int checkCount = 0;
    int passCount  = 0;

    mips_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .GlobalClock(clk), .GlobalReset(rst), .MemAddr(addr), .MemRead(rd),
        .MemWrite(wr), .MemWriteData(wdata), .MemReadData(rdata),
        .MemStall(stall), .AccessError(err)
    );

    mips_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dutZ (
        .GlobalClock(clk), .GlobalReset(rst), .MemAddr(zAddr), .MemRead(zRd),
        .MemWrite(zWr), .MemWriteData(zWdata), .MemReadData(zRdata),
        .MemStall(zStall), .AccessError(zErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one access starting in the current IDLE cycle (posedge+1).
    task automatic access(input bit sel, input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] d, output int stalls,
                          output logic [31:0] data, output logic e);
        bit done = 0;
        stalls = 0;
        if (sel) begin zAddr = a; zRd = r; zWr = w; zWdata = d; end
        else     begin addr  = a; rd  = r; wr  = w; wdata  = d; end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!(sel ? zStall : stall)) begin done = 1; break; end
            stalls++;
            @(posedge clk); #1;
        end
        if (!done) begin
            checkCount++;
            $display("FAIL timeout: no DONE within 20 cycles at addr %h", a);
        end
        data = sel ? zRdata : rdata;
        e    = sel ? zErr : err;
        @(posedge clk); #1;
        if (sel) begin zRd = 0; zWr = 0; end
        else     begin rd  = 0; wr  = 0; end
    endtask

    task automatic test_reset();
        int s; logic [31:0] d; logic e;
        rst = 1; addr = 32'h40; rd = 1; wr = 0; wdata = 0;
        zAddr = 0; zRd = 0; zWr = 0; zWdata = 0;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0);
        else passCount++;
        checkCount++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
        else passCount++;
        rst = 0;
        access(0, 32'h40, 1, 0, 0, s, d, e);
        checkCount++;
        if (s !== 3) $display("FAIL reset_first_latency: got %0d stall cycles want 3", s);
        else passCount++;
    endtask

    task automatic test_store_load();
        int s; logic [31:0] d; logic e;
        access(0, 32'h10, 0, 1, 32'h1234_5678, s, d, e);
        checkCount++;
        if (s !== 3) $display("FAIL store_stall: got %0d want 3", s);
        else passCount++;
        access(0, 32'h10, 1, 0, 0, s, d, e);
        checkCount++;
        if (s !== 3) $display("FAIL load_stall: got %0d want 3", s);
        else passCount++;
        checkCount++;
        if (d !== 32'h1234_5678) $display("FAIL load_data: got %h want %h", d, 32'h1234_5678);
        else passCount++;
        checkCount++;
        if (e !== 1'b0) $display("FAIL load_err: got %b want 0", e);
        else passCount++;
        access(0, 32'h0, 0, 1, 32'h0000_5A5A, s, d, e);
        checkCount++;
        if (rdata !== 32'h1234_5678) $display("FAIL rdata_hold: got %h want %h", rdata, 32'h1234_5678);
        else passCount++;
    endtask

    task automatic test_faults();
        int s; logic [31:0] d; logic e;
        access(0, 32'h13, 1, 0, 0, s, d, e);
        checkCount++;
        if (e !== 1'b1 || d !== 32'h0 || s !== 3)
            $display("FAIL misaligned_load: got err=%b data=%h stalls=%0d want err=1 data=0 stalls=3", e, d, s);
        else passCount++;
        checkCount++;
        if (err !== 1'b0) $display("FAIL err_pulse_width: got %b want 0 after DONE", err);
        else passCount++;
        access(0, 32'h400, 1, 0, 0, s, d, e);
        checkCount++;
        if (e !== 1'b1 || d !== 32'h0)
            $display("FAIL range_load: got err=%b data=%h want err=1 data=0", e, d);
        else passCount++;
        access(0, 32'h12, 0, 1, 32'hDEAD_DEAD, s, d, e);
        access(0, 32'h400, 0, 1, 32'hBEEF_BEEF, s, d, e);
        checkCount++;
        if (e !== 1'b1) $display("FAIL range_store_err: got %b want 1", e);
        else passCount++;
        access(0, 32'h10, 1, 0, 0, s, d, e);
        checkCount++;
        if (d !== 32'h1234_5678) $display("FAIL misaligned_no_write: got %h want %h", d, 32'h1234_5678);
        else passCount++;
        access(0, 32'h0, 1, 0, 0, s, d, e);
        checkCount++;
        if (d !== 32'h0000_5A5A) $display("FAIL range_no_write: got %h want %h", d, 32'h0000_5A5A);
        else passCount++;
    endtask

    task automatic test_both_strobes();
        int s; logic [31:0] d; logic e;
        access(0, 32'h20, 0, 1, 32'h1111_2222, s, d, e);
        access(0, 32'h20, 1, 1, 32'hFFFF_FFFF, s, d, e);
        checkCount++;
        if (e !== 1'b1 || d !== 32'h0)
            $display("FAIL both_strobes: got err=%b data=%h want err=1 data=0", e, d);
        else passCount++;
        access(0, 32'h20, 1, 0, 0, s, d, e);
        checkCount++;
        if (d !== 32'h1111_2222) $display("FAIL both_no_write: got %h want %h", d, 32'h1111_2222);
        else passCount++;
    endtask

    task automatic test_input_change();
        int s; logic [31:0] d; logic e;
        access(0, 32'h28, 0, 1, 32'h2828_2828, s, d, e);
        addr = 32'h24; wr = 1; rd = 0; wdata = 32'hAAAA_0001;
        @(posedge clk); #1;
        addr = 32'h28; wdata = 32'h5; wr = 0;
        repeat (3) @(posedge clk);
        #1;
        access(0, 32'h24, 1, 0, 0, s, d, e);
        checkCount++;
        if (d !== 32'hAAAA_0001) $display("FAIL latched_store: got %h want %h", d, 32'hAAAA_0001);
        else passCount++;
        access(0, 32'h28, 1, 0, 0, s, d, e);
        checkCount++;
        if (d !== 32'h2828_2828) $display("FAIL other_word_untouched: got %h want %h", d, 32'h2828_2828);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        int s; logic [31:0] d; logic e;
        access(0, 32'h30, 0, 1, 32'h0000_0BAD, s, d, e);
        addr = 32'h30; wr = 1; rd = 0; wdata = 32'h0000_C0DE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Reset lands on the edge that would have committed the store.
        rst = 1;
        @(posedge clk); #1;
        rst = 0; wr = 0;
        #1;
        checkCount++;
        if (stall !== 1'b0) $display("FAIL reset_mid_stall: got %b want 0", stall);
        else passCount++;
        @(posedge clk); #1;
        access(0, 32'h30, 1, 0, 0, s, d, e);
        checkCount++;
        if (d !== 32'h0000_0BAD) $display("FAIL reset_mid_discard: got %h want %h", d, 32'h0000_0BAD);
        else passCount++;
    endtask

    task automatic test_zero_wait();
        int s; logic [31:0] d; logic e;
        access(1, 32'h44, 0, 1, 32'hCAFE_0044, s, d, e);
        checkCount++;
        if (s !== 1) $display("FAIL zw_store_stall: got %0d want 1", s);
        else passCount++;
        access(1, 32'h44, 1, 0, 0, s, d, e);
        checkCount++;
        if (s !== 1 || d !== 32'hCAFE_0044 || e !== 1'b0)
            $display("FAIL zw_load: got stalls=%0d data=%h err=%b want 1 cafe0044 0", s, d, e);
        else passCount++;
        access(1, 32'h45, 1, 0, 0, s, d, e);
        checkCount++;
        if (s !== 1 || d !== 32'h0 || e !== 1'b1)
            $display("FAIL zw_fault: got stalls=%0d data=%h err=%b want 1 0 1", s, d, e);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_faults();
        test_both_strobes();
        test_input_change();
        test_reset_mid();
        test_zero_wait();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_mips_dmem_responder
`default_nettype wire
